// File: rtl/nv_dbg_misr_tap.sv
// Observation compaction tap: folds a wide debug bus into a MISR over a
// programmable beat window and keeps one registered bit alive for the sink.
module nv_dbg_misr_tap #(
  parameter int unsigned       IN_W  = 32,
  parameter int unsigned       SIG_W = 16,
  parameter logic [SIG_W-1:0]  POLY  = 16'h1021,
  parameter logic [SIG_W-1:0]  SEED  = 16'h0000,
  parameter int unsigned       WIN_W = 16
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic [IN_W-1:0]   obs_data,
  input  logic              obs_valid,
  input  logic              misr_en,
  input  logic              misr_clr,
  input  logic [WIN_W-1:0]  win_len,
  input  logic              snap_req,
  output logic              snap_ack,
  output logic [SIG_W-1:0]  snap_sig,
  output logic [WIN_W-1:0]  snap_cnt,
  output logic              busy,
  output logic              done,
  output logic              sink_bit
);

  localparam int unsigned NCH = (IN_W + SIG_W - 1) / SIG_W;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [SIG_W-1:0]     sig;
  logic [SIG_W-1:0]     sig_step;
  logic [SIG_W-1:0]     fold;
  logic [NCH*SIG_W-1:0] obs_pad;
  logic [WIN_W-1:0]     cnt;
  logic [WIN_W-1:0]     cnt_sat;
  logic [WIN_W:0]       cnt_p1;
  logic                 beat;
  logic                 win_hit;

  always_comb begin
    obs_pad = '0;
    obs_pad[IN_W-1:0] = obs_data;
    fold = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      fold = fold ^ obs_pad[i*SIG_W +: SIG_W];
    end
  end

  always_comb begin
    sig_step = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ fold;
    cnt_sat  = (cnt == '1) ? cnt : cnt + WIN_W'(1);
    // Compare one bit wider so a saturated counter can never match win_len.
    cnt_p1   = (WIN_W+1)'(cnt) + (WIN_W+1)'(1);
    win_hit  = (win_len != '0) && (cnt_p1 == (WIN_W+1)'(win_len));
    beat     = (state == RUN) && obs_valid;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (misr_clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (misr_en) state_nxt = RUN;
        RUN: begin
          if (obs_valid && win_hit) state_nxt = HOLD;
          else if (!misr_en)        state_nxt = IDLE;
        end
        HOLD: if (snap_req) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == HOLD);
  end

  // Snapshot samples pre-edge sig/cnt, so it ignores any clear or beat in the same cycle.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      sig      <= SEED;
      cnt      <= '0;
      sink_bit <= 1'b0;
      snap_ack <= 1'b0;
      snap_sig <= '0;
      snap_cnt <= '0;
    end else begin
      sink_bit <= ^sig;
      snap_ack <= snap_req;
      if (snap_req) begin
        snap_sig <= sig;
        snap_cnt <= cnt;
      end
      if (misr_clr) begin
        sig <= SEED;
        cnt <= '0;
      end else if (beat) begin
        sig <= sig_step;
        cnt <= cnt_sat;
      end
    end
  end

endmodule

// File: tb/tb_nv_dbg_misr_tap.sv
// Randomized and directed bench for nv_dbg_misr_tap against a behavioural model.
module tb_nv_dbg_misr_tap;

  logic        clk;
  logic        rst_n;
  logic [31:0] obs_data;
  logic        obs_valid;
  logic        misr_en;
  logic        misr_clr;
  logic [15:0] win_len;
  logic        snap_req;
  logic        snap_ack;
  logic [15:0] snap_sig;
  logic [15:0] snap_cnt;
  logic        busy;
  logic        done;
  logic        sink_bit;

  int unsigned total = 0;
  int unsigned bad   = 0;

  nv_dbg_misr_tap #(
    .IN_W(32), .SIG_W(16), .POLY(16'h1021), .SEED(16'h0000), .WIN_W(16)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rst_n),
    .obs_data       (obs_data),
    .obs_valid      (obs_valid),
    .misr_en        (misr_en),
    .misr_clr       (misr_clr),
    .win_len        (win_len),
    .snap_req       (snap_req),
    .snap_ack       (snap_ack),
    .snap_sig       (snap_sig),
    .snap_cnt       (snap_cnt),
    .busy           (busy),
    .done           (done),
    .sink_bit       (sink_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: mode 0 = idle, 1 = running window, 2 = window complete.
  int unsigned m_sig, m_cnt, m_mode, m_ssig, m_scnt, m_ack, m_sink;

  function automatic int unsigned parity16(input int unsigned v);
    int unsigned p = 0;
    for (int b = 0; b < 16; b++) p = p + ((v >> b) % 2);
    return p % 2;
  endfunction

  function automatic int unsigned step(input int unsigned s, input int unsigned d);
    int unsigned f = (d % 65536) ^ (d / 65536);
    int unsigned r = (s * 2) % 65536;
    if (s >= 32768) r = r ^ 32'h1021;
    return r ^ f;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sig = 0; m_cnt = 0; m_mode = 0;
      m_ssig = 0; m_scnt = 0; m_ack = 0; m_sink = 0;
    end else begin
      m_sink = parity16(m_sig);
      m_ack  = snap_req ? 1 : 0;
      if (snap_req) begin
        m_ssig = m_sig;
        m_scnt = m_cnt;
      end
      if (misr_clr) begin
        m_sig = 0; m_cnt = 0; m_mode = 0;
      end else if (m_mode == 0) begin
        if (misr_en) m_mode = 1;
      end else if (m_mode == 1) begin
        if (obs_valid) begin
          m_sig = step(m_sig, obs_data);
          if (win_len != 0 && m_cnt + 1 == win_len) m_mode = 2;
          else if (!misr_en) m_mode = 0;
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else if (!misr_en) begin
          m_mode = 0;
        end
      end else begin
        if (snap_req) m_mode = 0;
      end
    end
  end

  task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    chk("snap_ack", 32'(snap_ack), m_ack);
    chk("snap_sig", 32'(snap_sig), m_ssig);
    chk("snap_cnt", 32'(snap_cnt), m_scnt);
    chk("busy",     32'(busy),     (m_mode == 1) ? 1 : 0);
    chk("done",     32'(done),     (m_mode == 2) ? 1 : 0);
    chk("sink_bit", 32'(sink_bit), m_sink);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    obs_valid = 1'b0; misr_clr = 1'b0; snap_req = 1'b0; obs_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; misr_en = 1'b0; win_len = '0;
    idle_in();
    cyc(); cyc();
    chk("rst_ack", 32'(snap_ack), 0);
    chk("rst_sig", 32'(snap_sig), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sink", 32'(sink_bit), 0);
    rst_n = 1'b1;

    // Three-beat window of ones
    misr_en = 1'b1; win_len = 16'd3;
    cyc();
    chk("t1_busy", 32'(busy), 1);
    obs_valid = 1'b1; obs_data = 32'h0000_0001;
    cyc(); chk("t1_m1", m_sig, 16'h0001);
    cyc(); chk("t1_m2", m_sig, 16'h0003);
    cyc(); chk("t1_m3", m_sig, 16'h0007);
    chk("t1_done", 32'(done), 1);
    cyc(); chk("t1_extra", m_sig, 16'h0007);
    chk("t1_done2", 32'(done), 1);

    // Snapshot from HOLD
    obs_valid = 1'b0; snap_req = 1'b1;
    cyc();
    chk("t2_ack", 32'(snap_ack), 1);
    chk("t2_sig", 32'(snap_sig), 16'h0007);
    chk("t2_cnt", 32'(snap_cnt), 3);
    chk("t2_done", 32'(done), 0);
    snap_req = 1'b0;
    cyc();
    chk("t2_ack_low", 32'(snap_ack), 0);

    // Feedback path
    misr_en = 1'b0; misr_clr = 1'b1; cyc();
    misr_clr = 1'b0; win_len = '0; misr_en = 1'b1; cyc();
    obs_valid = 1'b1; obs_data = 32'h0000_8000; cyc();
    chk("t3_m8000", m_sig, 16'h8000);
    obs_data = 32'h0; cyc();
    chk("t3_m1021", m_sig, 16'h1021);
    obs_valid = 1'b0; snap_req = 1'b1; cyc();
    chk("t3_sig", 32'(snap_sig), 16'h1021);
    chk("t3_cnt", 32'(snap_cnt), 2);
    snap_req = 1'b0;

    // Fold across both halves
    misr_clr = 1'b1; cyc();
    misr_clr = 1'b0; cyc();
    obs_valid = 1'b1; obs_data = 32'hA5A5_5A5A; cyc();
    chk("t3_mffff", m_sig, 16'hFFFF);
    obs_data = 32'h0000_0001; cyc();
    chk("t3_sink0", 32'(sink_bit), 0);
    chk("t3_mefde", m_sig, 16'hEFDE);
    obs_valid = 1'b0; snap_req = 1'b1; cyc();
    chk("t3_sink1", 32'(sink_bit), 1);
    chk("t3_fsig", 32'(snap_sig), 16'hEFDE);
    snap_req = 1'b0;

    // Clear with simultaneous snapshot and beat
    misr_clr = 1'b1; cyc();
    misr_clr = 1'b0; cyc();
    obs_valid = 1'b1; obs_data = 32'h0000_0001; cyc(); cyc();
    misr_clr = 1'b1; snap_req = 1'b1; cyc();
    chk("t5_ack", 32'(snap_ack), 1);
    chk("t5_sig", 32'(snap_sig), 16'h0003);
    chk("t5_cnt", 32'(snap_cnt), 2);
    chk("t5_busy", 32'(busy), 0);
    idle_in(); misr_en = 1'b0; cyc();
    snap_req = 1'b1; cyc();
    chk("t5_clr_sig", 32'(snap_sig), 0);
    chk("t5_clr_cnt", 32'(snap_cnt), 0);
    snap_req = 1'b0;

    // Free-running saturation
    misr_en = 1'b1; win_len = '0; cyc();
    obs_valid = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      obs_data = $urandom;
      cyc();
    end
    chk("t4_busy", 32'(busy), 1);
    chk("t4_done", 32'(done), 0);
    obs_valid = 1'b0; snap_req = 1'b1; cyc();
    chk("t4_cnt", 32'(snap_cnt), 16'hFFFF);
    snap_req = 1'b0;

    // Async reset mid-window with an ack in flight
    misr_clr = 1'b1; cyc();
    misr_clr = 1'b0; cyc();
    obs_valid = 1'b1; obs_data = 32'h0000_0001;
    repeat (5) cyc();
    obs_valid = 1'b0; snap_req = 1'b1; cyc();
    chk("t6_pre_cnt", 32'(snap_cnt), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ack", 32'(snap_ack), 0);
    chk("t6_sig", 32'(snap_sig), 0);
    chk("t6_cnt", 32'(snap_cnt), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_sink", 32'(sink_bit), 0);
    idle_in(); misr_en = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    misr_en = 1'b1; win_len = 16'd2; cyc();
    obs_valid = 1'b1; obs_data = 32'h0000_0001; cyc(); cyc();
    chk("t6_done", 32'(done), 1);
    obs_valid = 1'b0; snap_req = 1'b1; cyc();
    chk("t6_rsig", 32'(snap_sig), 16'h0003);
    chk("t6_rcnt", 32'(snap_cnt), 2);
    snap_req = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      obs_valid = 1'($urandom_range(0, 1));
      obs_data  = $urandom;
      misr_en   = ($urandom_range(0, 9) != 0);
      misr_clr  = ($urandom_range(0, 49) == 0);
      snap_req  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 4))
          0: win_len = 16'd0;
          1: win_len = 16'd1;
          2: win_len = 16'd3;
          3: win_len = 16'd5;
          default: win_len = 16'd8;
        endcase
      end
      cyc();
    end
    idle_in();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nv_dbg_misr_tap.md
Name: nv_dbg_misr_tap

Overview:
- Observation-compaction stage placed directly upstream of a black-box sink cell.
- Folds a wide debug/observation bus into a multiple-input signature register (MISR) over a programmable beat window.
- Drives a single registered bit into the sink so the observed logic survives synthesis.
- Provides a snapshot handshake so firmware or a bench can read the signature and beat count.

Parameters:
- IN_W, 32, observation bus width (≥1).
- SIG_W, 16, signature width (≥2).
- POLY, 16'h1021, feedback polynomial (SIG_W bits; bit0 is the x^0 term).
- SEED, 16'h0000, signature value after reset or clear.
- WIN_W, 16, width of window length and beat counter.

Ports:
- nvdla_core_clk  input  1  core clock; all state on rising edge.
- nvdla_core_rstn  input  1  asynchronous active-low reset.
- obs_data  input  IN_W  observation data.
- obs_valid  input  1  obs_data qualifies this cycle.
- misr_en  input  1  level; arms capture.
- misr_clr  input  1  pulse; synchronous clear.
- win_len  input  WIN_W  beats per window; 0 = free-running.
- snap_req  input  1  pulse; snapshot request.
- snap_ack  output  1  one-cycle pulse; snap_sig/snap_cnt updated.
- snap_sig  output  SIG_W  captured signature.
- snap_cnt  output  WIN_W  captured beat count.
- busy  output  1  state == RUN.
- done  output  1  state == HOLD.
- sink_bit  output  1  registered XOR-reduction of signature; feeds the sink cell.

Behaviour:
- Reset (async, rstn=0): state=IDLE, sig=SEED, cnt=0, snap_sig=0, snap_cnt=0, snap_ack=0, sink_bit=0. Mid-window reset discards everything; no ack is issued.
- Fold: obs_data is zero-padded to a multiple of SIG_W and split into SIG_W-bit chunks, which are XORed together to form fold.
- Step: next = {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold.
- States:
  - IDLE: sig and cnt hold. misr_en=1 → RUN next cycle; sig and cnt are not reseeded (clear is explicit).
  - RUN: on obs_valid, sig ← step and cnt ← cnt+1 (saturates at all-ones).
    - win_len≠0 and the beat makes cnt+1 == win_len → HOLD (that beat is included).
    - misr_en=0 → IDLE; a beat in the same cycle is still absorbed.
  - HOLD: sig and cnt frozen; obs_valid ignored. Leaves on a completed snapshot → IDLE, or on misr_clr.
- Capture latency: a beat presented at edge N is visible in sig after edge N.
- sink_bit: sink_bit ← ^sig, one cycle behind sig.
- Snapshot:
  - snap_req in any state → at the next edge, snap_sig ← sig, snap_cnt ← cnt, snap_ack=1 for exactly one cycle.
  - Values are the pre-edge sig/cnt; a beat absorbed on the snap_req cycle is excluded.
  - snap_req while snap_ack=1 is accepted (back-to-back acks allowed).
- misr_clr (highest priority): sig ← SEED, cnt ← 0, state ← IDLE.
  - Simultaneous snap_req: the snapshot captures pre-clear values and the ack still fires.
  - Simultaneous obs_valid: the beat is dropped.
- Simultaneous final beat and snap_req in RUN: the snapshot gets pre-beat values, and the state still goes to HOLD.
- win_len is sampled live; lowering it below cnt means HOLD is never reached via ==, so the window runs until clear or disable.

Test Plan:
1. Reset, misr_en=1, win_len=3, obs_data=32'h0000_0001 valid 3 cycles → sig 0x0001, 0x0003, 0x0007; done=1 after beat 3; a 4th beat is ignored.
2. In HOLD with sig=0x0007, pulse snap_req → next cycle snap_ack=1 for one cycle, snap_sig=0x0007, snap_cnt=3, state=IDLE.
3. Feedback: force sig=0x8000 via beats then obs_data=0 → sig=0x1021. Fold check: from SEED 0, one beat of 32'hA5A5_5A5A → sig=0xFFFF, and sink_bit=0 one cycle later.
4. win_len=0, 70000 valid beats → busy stays 1, cnt saturates at 0xFFFF, done never asserts.
5. misr_clr with snap_req and obs_valid in the same cycle (sig=0x0003, cnt=2) → snap_sig=0x0003, snap_cnt=2, ack fires, sig=SEED, cnt=0, state IDLE.
6. Assert rstn low mid-window (cnt=5) → all outputs 0 asynchronously, no snap_ack; after release, the first window starts from SEED.
